// File: rtl/id_pkg.sv
// ---------------------------------------------------------------------------
// id_pkg
// Shared constants for the instruction-decode stage:
//   CTRL_*  bit positions inside the 9-bit control word
//           {J,JC,INA,RM,WM,SIN,SOUT,WR,NEQ}
//   OPC_*   3-bit opcode encodings
//   ctrl_decode(opc, funct0)  opcode -> control word
// ---------------------------------------------------------------------------
package id_pkg;

    localparam int CTRL_W    = 9;
    localparam int CTRL_J    = 8;
    localparam int CTRL_JC   = 7;
    localparam int CTRL_INA  = 6;
    localparam int CTRL_RM   = 5;
    localparam int CTRL_WM   = 4;
    localparam int CTRL_SIN  = 3;
    localparam int CTRL_SOUT = 2;
    localparam int CTRL_WR   = 1;
    localparam int CTRL_NEQ  = 0;

    localparam logic [2:0] OPC_ALU   = 3'b000;
    localparam logic [2:0] OPC_ALUI  = 3'b001;
    localparam logic [2:0] OPC_LOAD  = 3'b010;
    localparam logic [2:0] OPC_STORE = 3'b011;
    localparam logic [2:0] OPC_JMP   = 3'b100;
    localparam logic [2:0] OPC_BEQ   = 3'b101;
    localparam logic [2:0] OPC_BNE   = 3'b110;
    localparam logic [2:0] OPC_IO    = 3'b111;

    // funct0 only matters for the IO opcode: 0 = IN, 1 = OUT.
    function automatic logic [CTRL_W-1:0] ctrl_decode(input logic [2:0] opc,
                                                       input logic       funct0);
        logic [CTRL_W-1:0] c;
        c = '0;
        case (opc)
            OPC_ALU:   c[CTRL_WR] = 1'b1;
            OPC_ALUI:  begin c[CTRL_INA] = 1'b1; c[CTRL_WR] = 1'b1; end
            OPC_LOAD:  begin c[CTRL_RM]  = 1'b1; c[CTRL_WR] = 1'b1; end
            OPC_STORE: c[CTRL_WM] = 1'b1;
            OPC_JMP:   c[CTRL_J]  = 1'b1;
            OPC_BEQ:   c[CTRL_JC] = 1'b1;
            OPC_BNE:   begin c[CTRL_JC] = 1'b1; c[CTRL_NEQ] = 1'b1; end
            default: begin
                if (funct0) begin
                    c[CTRL_SOUT] = 1'b1;
                end else begin
                    c[CTRL_SIN] = 1'b1;
                    c[CTRL_WR]  = 1'b1;
                end
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_regbank.sv
// ---------------------------------------------------------------------------
// id_regbank
// NREGS x DATA_W register bank, one combinational read port and one
// synchronous write port, asynchronous active-high reset clears every entry.
// Optional macro ID_WB_BYPASS_EN: a same-cycle write to the register being
// read is forwarded to the read port (write-through). Without it the read
// returns the value held before the write.
// Ports:
//   clock, reset          clock / async active-high reset
//   we, waddr, wdata      write-back port
//   raddr, rdata          combinational read port
// ---------------------------------------------------------------------------
module id_regbank #(
    parameter  int DATA_W = 8,
    parameter  int NREGS  = 4,
    localparam int REG_AW = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = regs[raddr];
`ifdef ID_WB_BYPASS_EN
        if (we && (waddr == raddr)) begin
            rdata = wdata;
        end
`endif
    end

endmodule

// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe
// Instruction-decode stage with its own ID/EX pipeline register. Decodes the
// opcode into a 9-bit control word, sign-extends the immediate, reads the
// register bank, and inserts a one-cycle bubble on a load-use hazard.
// Optional macro ID_WB_BYPASS_EN enables write-through in the register bank.
// Ports:
//   clock, reset                      clock / async active-high reset
//   if_valid, if_pc, if_inst, id_ready  IF-side handshake
//   flush                             EX redirect, squashes the ID slot
//   wb_we, wb_rd, wb_data             register write-back
//   ex_ready, ex_valid                EX-side handshake
//   ex_pc, ex_regval, ex_imm, ex_rd, ex_funct, ex_ctrl  ID/EX register
//   stall_cnt                         saturating load-use bubble counter
// ---------------------------------------------------------------------------
module id_stage_pipe
    import id_pkg::*;
#(
    parameter  int DATA_W      = 8,
    parameter  int INST_W      = 8,
    parameter  int NREGS       = 4,
    parameter  int IMM_W       = 5,
    parameter  int STALL_CNT_W = 16,
    localparam int REG_AW      = $clog2(NREGS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   if_valid,
    input  logic [DATA_W-1:0]      if_pc,
    input  logic [INST_W-1:0]      if_inst,
    output logic                   id_ready,
    input  logic                   flush,
    input  logic                   wb_we,
    input  logic [REG_AW-1:0]      wb_rd,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic                   ex_ready,
    output logic                   ex_valid,
    output logic [DATA_W-1:0]      ex_pc,
    output logic [DATA_W-1:0]      ex_regval,
    output logic [DATA_W-1:0]      ex_imm,
    output logic [REG_AW-1:0]      ex_rd,
    output logic [2:0]             ex_funct,
    output logic [CTRL_W-1:0]      ex_ctrl,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + STALL_CNT_W'(1);
    endfunction

    // ---- stage p0: decode of the IF instruction ----
    logic [2:0]               opc_p0;
    logic [REG_AW-1:0]        rs_p0;
    logic [2:0]               funct_p0;
    logic signed [IMM_W-1:0]  imm_raw_p0;
    logic signed [DATA_W-1:0] imm_ext_p0;
    logic [DATA_W-1:0]        regval_p0;
    logic                     accept_p0;
    logic                     hazard_p0;

    assign opc_p0     = if_inst[INST_W-1 -: 3];
    assign rs_p0      = if_inst[INST_W-4 -: REG_AW];
    assign funct_p0   = if_inst[2:0];
    assign imm_raw_p0 = if_inst[IMM_W-1:0];
    assign imm_ext_p0 = DATA_W'(imm_raw_p0);

    id_regbank #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regbank (
        .clock (clock),
        .reset (reset),
        .we    (wb_we),
        .waddr (wb_rd),
        .wdata (wb_data),
        .raddr (rs_p0),
        .rdata (regval_p0)
    );

    // ---- stage p1: ID/EX register ----
    logic                     vld_p1;
    logic [DATA_W-1:0]        pc_p1;
    logic [DATA_W-1:0]        regval_p1;
    logic signed [DATA_W-1:0] imm_p1;
    logic [REG_AW-1:0]        rd_p1;
    logic [2:0]               funct_p1;
    logic [CTRL_W-1:0]        ctrl_p1;
    logic [STALL_CNT_W-1:0]   stall_cnt_p1;

    // A load in ID/EX whose destination is the source being read now cannot
    // be forwarded in time, so the dependent instruction waits one slot.
    assign accept_p0 = !vld_p1 || ex_ready;
    assign hazard_p0 = if_valid && vld_p1 && ctrl_p1[CTRL_RM] && (rd_p1 == rs_p0);
    assign id_ready  = accept_p0 && (flush || !hazard_p0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1       <= 1'b0;
            pc_p1        <= '0;
            regval_p1    <= '0;
            imm_p1       <= '0;
            rd_p1        <= '0;
            funct_p1     <= '0;
            ctrl_p1      <= '0;
            stall_cnt_p1 <= '0;
        end else if (flush) begin
            vld_p1  <= 1'b0;
            ctrl_p1 <= '0;
        end else if (!accept_p0) begin
            vld_p1  <= vld_p1;
        end else if (hazard_p0) begin
            vld_p1       <= 1'b0;
            ctrl_p1      <= '0;
            stall_cnt_p1 <= sat_inc(stall_cnt_p1);
        end else begin
            vld_p1    <= if_valid;
            pc_p1     <= if_pc;
            regval_p1 <= regval_p0;
            imm_p1    <= imm_ext_p0;
            rd_p1     <= rs_p0;
            funct_p1  <= funct_p0;
            ctrl_p1   <= if_valid ? ctrl_decode(opc_p0, funct_p0[0]) : '0;
        end
    end

    assign ex_valid  = vld_p1;
    assign ex_pc     = pc_p1;
    assign ex_regval = regval_p1;
    assign ex_imm    = imm_p1;
    assign ex_rd     = rd_p1;
    assign ex_funct  = funct_p1;
    assign ex_ctrl   = ctrl_p1;
    assign stall_cnt = stall_cnt_p1;

endmodule

// File: tb/tb_id_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_stage_pipe
// Directed bench for id_stage_pipe: a table of decode vectors plus
// hand-written sequences for hazard, backpressure, flush, write-through and
// asynchronous reset.
// ---------------------------------------------------------------------------
module tb_id_stage_pipe;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_valid = 1'b0;
    logic [7:0]  if_pc = '0;
    logic [7:0]  if_inst = '0;
    logic        id_ready;
    logic        flush = 1'b0;
    logic        wb_we = 1'b0;
    logic [1:0]  wb_rd = '0;
    logic [7:0]  wb_data = '0;
    logic        ex_ready = 1'b1;
    logic        ex_valid;
    logic [7:0]  ex_pc;
    logic [7:0]  ex_regval;
    logic [7:0]  ex_imm;
    logic [1:0]  ex_rd;
    logic [2:0]  ex_funct;
    logic [8:0]  ex_ctrl;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    id_stage_pipe dut (
        .clock     (clock),
        .reset     (reset),
        .if_valid  (if_valid),
        .if_pc     (if_pc),
        .if_inst   (if_inst),
        .id_ready  (id_ready),
        .flush     (flush),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .ex_ready  (ex_ready),
        .ex_valid  (ex_valid),
        .ex_pc     (ex_pc),
        .ex_regval (ex_regval),
        .ex_imm    (ex_imm),
        .ex_rd     (ex_rd),
        .ex_funct  (ex_funct),
        .ex_ctrl   (ex_ctrl),
        .stall_cnt (stall_cnt)
    );

    typedef struct {
        logic       vld;
        logic [7:0] inst;
        logic [7:0] pc;
        logic       e_vld;
        logic [7:0] e_regval;
        logic [7:0] e_imm;
        logic [8:0] e_ctrl;
        logic [1:0] e_rd;
        logic [2:0] e_funct;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic v, input logic [7:0] inst, input logic [7:0] pc);
        if_valid = v;
        if_inst  = inst;
        if_pc    = pc;
    endtask

    logic [7:0] exp_bypass;

    initial begin
        // ctrl bits: J=100 JC=080 INA=040 RM=020 WM=010 SIN=008 SOUT=004 WR=002 NEQ=001
        vecs[0]  = '{1'b1, 8'h10, 8'h04, 1'b1, 8'h5A, 8'hF0, 9'h002, 2'd2, 3'd0};
        vecs[1]  = '{1'b1, 8'h3F, 8'h05, 1'b1, 8'h33, 8'hFF, 9'h042, 2'd3, 3'd7};
        vecs[2]  = '{1'b1, 8'h2F, 8'h06, 1'b1, 8'h22, 8'h0F, 9'h042, 2'd1, 3'd7};
        vecs[3]  = '{1'b1, 8'h63, 8'h07, 1'b1, 8'h11, 8'h03, 9'h010, 2'd0, 3'd3};
        vecs[4]  = '{1'b1, 8'h80, 8'h08, 1'b1, 8'h11, 8'h00, 9'h100, 2'd0, 3'd0};
        vecs[5]  = '{1'b1, 8'hA9, 8'h09, 1'b1, 8'h22, 8'h09, 9'h080, 2'd1, 3'd1};
        vecs[6]  = '{1'b1, 8'hD2, 8'h0A, 1'b1, 8'h5A, 8'hF2, 9'h081, 2'd2, 3'd2};
        vecs[7]  = '{1'b1, 8'hE0, 8'h0B, 1'b1, 8'h11, 8'h00, 9'h00A, 2'd0, 3'd0};
        vecs[8]  = '{1'b1, 8'hF9, 8'h0C, 1'b1, 8'h33, 8'hF9, 9'h004, 2'd3, 3'd1};
        vecs[9]  = '{1'b0, 8'h48, 8'h0D, 1'b0, 8'h22, 8'h08, 9'h000, 2'd1, 3'd0};
        vecs[10] = '{1'b1, 8'h48, 8'h0E, 1'b1, 8'h22, 8'h08, 9'h022, 2'd1, 3'd0};

        // Reset state
        step();
        chk("rst_valid", 32'(ex_valid), 32'h0);
        chk("rst_ctrl", 32'(ex_ctrl), 32'h0);
        chk("rst_cnt", 32'(stall_cnt), 32'h0);
        reset = 1'b0;

        // Load the register bank, no instruction in flight
        wb_we = 1'b1;
        for (int r = 0; r < 4; r++) begin
            wb_rd   = 2'(r);
            wb_data = (r == 0) ? 8'h11 : (r == 1) ? 8'h22 : (r == 2) ? 8'h5A : 8'h33;
            step();
            chk("idle_valid", 32'(ex_valid), 32'h0);
        end
        wb_we = 1'b0;

        // Decode table, EX always ready, no hazards between entries
        for (int i = 0; i < 11; i++) begin
            present(vecs[i].vld, vecs[i].inst, vecs[i].pc);
            #1;
            chk($sformatf("v%0d_id_ready", i), 32'(id_ready), 32'h1);
            step();
            chk($sformatf("v%0d_valid", i), 32'(ex_valid), 32'(vecs[i].e_vld));
            chk($sformatf("v%0d_ctrl", i), 32'(ex_ctrl), 32'(vecs[i].e_ctrl));
            chk($sformatf("v%0d_regval", i), 32'(ex_regval), 32'(vecs[i].e_regval));
            chk($sformatf("v%0d_imm", i), 32'(ex_imm), 32'(vecs[i].e_imm));
            chk($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d_funct", i), 32'(ex_funct), 32'(vecs[i].e_funct));
            chk($sformatf("v%0d_pc", i), 32'(ex_pc), 32'(vecs[i].pc));
        end

        // Load-use: LOAD r1 sits in ID/EX (last table entry), ALU reads r1
        present(1'b1, 8'h08, 8'h20);
        #1;
        chk("hz_id_ready", 32'(id_ready), 32'h0);
        step();
        chk("hz_bubble_valid", 32'(ex_valid), 32'h0);
        chk("hz_bubble_ctrl", 32'(ex_ctrl), 32'h0);
        chk("hz_cnt", 32'(stall_cnt), 32'h1);
        chk("hz_after_id_ready", 32'(id_ready), 32'h1);
        step();
        chk("hz_issue_valid", 32'(ex_valid), 32'h1);
        chk("hz_issue_ctrl", 32'(ex_ctrl), 32'h002);
        chk("hz_issue_pc", 32'(ex_pc), 32'h20);
        chk("hz_issue_regval", 32'(ex_regval), 32'h22);

        // LOAD r1 followed by reader of r2: no hazard
        present(1'b1, 8'h48, 8'h21);
        step();
        present(1'b1, 8'h10, 8'h22);
        #1;
        chk("nohz_id_ready", 32'(id_ready), 32'h1);
        step();
        chk("nohz_valid", 32'(ex_valid), 32'h1);
        chk("nohz_cnt", 32'(stall_cnt), 32'h1);

        // Backpressure: ID/EX holds for 3 cycles
        present(1'b1, 8'h10, 8'h30);
        step();
        ex_ready = 1'b0;
        present(1'b1, 8'h3F, 8'h31);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_id_ready", 32'(id_ready), 32'h0);
            step();
            chk("bp_valid", 32'(ex_valid), 32'h1);
            chk("bp_pc", 32'(ex_pc), 32'h30);
            chk("bp_ctrl", 32'(ex_ctrl), 32'h002);
            chk("bp_regval", 32'(ex_regval), 32'h5A);
        end
        ex_ready = 1'b1;
        step();
        chk("bp_release_pc", 32'(ex_pc), 32'h31);
        chk("bp_release_ctrl", 32'(ex_ctrl), 32'h042);

        // Flush while a load-use hazard is pending
        present(1'b1, 8'h48, 8'h40);
        step();
        present(1'b1, 8'h08, 8'h41);
        flush = 1'b1;
        #1;
        chk("fl_id_ready", 32'(id_ready), 32'h1);
        step();
        flush = 1'b0;
        chk("fl_valid", 32'(ex_valid), 32'h0);
        chk("fl_ctrl", 32'(ex_ctrl), 32'h0);
        chk("fl_cnt", 32'(stall_cnt), 32'h1);

        // Write-back to r3 in the same cycle r3 is read
`ifdef ID_WB_BYPASS_EN
        exp_bypass = 8'hA5;
`else
        exp_bypass = 8'h33;
`endif
        wb_we = 1'b1; wb_rd = 2'd3; wb_data = 8'hA5;
        present(1'b1, 8'h18, 8'h50);
        step();
        wb_we = 1'b0;
        chk("wb_same_cycle", 32'(ex_regval), 32'(exp_bypass));
        present(1'b1, 8'h18, 8'h51);
        step();
        chk("wb_next_cycle", 32'(ex_regval), 32'hA5);

        // Asynchronous reset in the middle of a stall
        present(1'b1, 8'h48, 8'h60);
        step();
        present(1'b1, 8'h08, 8'h61);
        step();
        chk("rs_stall_cnt", 32'(stall_cnt), 32'h2);
        #2;
        reset = 1'b1;
        #1;
        chk("rs_valid", 32'(ex_valid), 32'h0);
        chk("rs_ctrl", 32'(ex_ctrl), 32'h0);
        chk("rs_pc", 32'(ex_pc), 32'h0);
        chk("rs_regval", 32'(ex_regval), 32'h0);
        chk("rs_imm", 32'(ex_imm), 32'h0);
        chk("rs_cnt", 32'(stall_cnt), 32'h0);
        step();
        reset = 1'b0;
        present(1'b1, 8'h08, 8'h61);
        #1;
        chk("rs_re_id_ready", 32'(id_ready), 32'h1);
        step();
        chk("rs_re_valid", 32'(ex_valid), 32'h1);
        chk("rs_re_pc", 32'(ex_pc), 32'h61);
        chk("rs_re_regval", 32'(ex_regval), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
